// File: rtl/img_pkg.sv
// Shared BMP constants, FSM encoding and geometry helpers for the image
// read/write paths.
package img_pkg;

  localparam int BMP_HEADER_NUM = 54;
  localparam int BMP_DIB_SIZE   = 40;
  localparam int BMP_BPP        = 24;
  localparam int BMP_PPM        = 2835;

  // Writer FSM encoding, kept as plain constants so legacy blocks can share it
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_PIX  = 3'd2;
  localparam logic [2:0] ST_PAD  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Row length in bytes, rounded up to a 4-byte boundary
  function automatic int bmp_stride(input int width);
    return ((width * 3 + 3) / 4) * 4;
  endfunction

endpackage

// File: rtl/bmp_write_stream_if.sv
// Pixel-in / byte-out handshake bundle for the BMP writer.
interface bmp_write_stream_if;
  logic       start;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] DATA_R;
  logic [7:0] DATA_G;
  logic [7:0] DATA_B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       busy;
  logic       done;

  modport master (
    output start, pix_valid, DATA_R, DATA_G, DATA_B, out_ready,
    input  pix_ready, out_valid, out_byte, out_last, busy, done
  );

  modport slave (
    input  start, pix_valid, DATA_R, DATA_G, DATA_B, out_ready,
    output pix_ready, out_valid, out_byte, out_last, busy, done
  );
endinterface

// File: rtl/bmp_header_rom.sv
// Combinational 54-byte BMP header lookup. Shared with the reader, which
// compares incoming header bytes against it.
module bmp_header_rom
  import img_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic [5:0] hdr_idx,
  output logic [7:0] hdr_byte
);

  localparam int STRIDE    = bmp_stride(WIDTH);
  localparam int IMG_SIZE  = STRIDE * HEIGHT;
  localparam int FILE_SIZE = BMP_HEADER_NUM + IMG_SIZE;

  // After the 2-byte 'BM' magic every field lands on a 4-byte word
  // (the two 16-bit fields planes/bpp share one word), so the header is
  // a table of 13 little-endian words indexed by (idx-2)/4.
  logic [5:0]  off;
  logic [31:0] field;

  // Select the word, then the byte lane within it
  always_comb begin
    off   = hdr_idx - 6'd2;
    field = '0;
    case (off[5:2])
      4'd0:    field = 32'(FILE_SIZE);
      4'd1:    field = '0;                              // reserved
      4'd2:    field = 32'(BMP_HEADER_NUM);             // pixel data offset
      4'd3:    field = 32'(BMP_DIB_SIZE);
      4'd4:    field = 32'(WIDTH);
      4'd5:    field = 32'(-HEIGHT);                    // negative: top-down rows
      4'd6:    field = {16'(BMP_BPP), 16'd1};           // planes=1, bpp=24
      4'd7:    field = '0;                              // no compression
      4'd8:    field = 32'(IMG_SIZE);
      4'd9:    field = 32'(BMP_PPM);
      4'd10:   field = 32'(BMP_PPM);
      default: field = '0;                              // palette counts
    endcase
    hdr_byte = field[{off[1:0], 3'b000} +: 8];
    if (hdr_idx < 6'd2)
      hdr_byte = hdr_idx[0] ? 8'h4D : 8'h42;
    else if (hdr_idx >= 6'(BMP_HEADER_NUM))
      hdr_byte = '0;
  end

endmodule

// File: rtl/bmp_write_stream.sv
// Streams a raster-order RGB888 frame out as a complete top-down 24-bit BMP
// file: header, pixel bytes, and zero padding to a 4-byte row stride.
module bmp_write_stream
  import img_pkg::*;
#(
  parameter int WIDTH     = 768,
  parameter int HEIGHT    = 512,
  parameter int BGR_ORDER = 1
) (
  input logic               HCLK,
  input logic               HRESET,
  bmp_write_stream_if.slave bus
);

  localparam int STRIDE    = bmp_stride(WIDTH);
  localparam int PAD_BYTES = STRIDE - WIDTH * 3;
  localparam int FILE_SIZE = BMP_HEADER_NUM + STRIDE * HEIGHT;

  logic [2:0]  state;
  logic [5:0]  hdr_idx;
  logic [10:0] col;
  logic [9:0]  row;
  logic [1:0]  pad_cnt;
  logic [1:0]  phase;
  logic [31:0] byte_cnt;
  logic        hold_full;
  rgb_t        hold;

  logic [7:0]  hdr_byte;
  logic [7:0]  pix_byte;
  logic        xfer;
  logic        pix_take;
  logic        row_last;

  bmp_header_rom #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hdr (
    .hdr_idx  (hdr_idx),
    .hdr_byte (hdr_byte)
  );

  // All outputs decode from registered state, so an asynchronous reset
  // clears them in the same cycle it is asserted.
  assign bus.pix_ready = (state == ST_PIX) && !hold_full;
  assign bus.out_valid = (state == ST_HDR) || (state == ST_PAD) ||
                         ((state == ST_PIX) && hold_full);
  assign bus.out_last  = bus.out_valid && (byte_cnt == 32'(FILE_SIZE - 1));
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_FIN);

  assign xfer     = bus.out_valid && bus.out_ready;
  assign pix_take = bus.pix_valid && bus.pix_ready;
  assign row_last = (row == 10'(HEIGHT - 1));

  // Byte order within a pixel: B,G,R for standard BMP, else R,G,B
  always_comb begin
    case (phase)
      2'd0:    pix_byte = (BGR_ORDER != 0) ? hold.b : hold.r;
      2'd1:    pix_byte = hold.g;
      default: pix_byte = (BGR_ORDER != 0) ? hold.r : hold.b;
    endcase
  end

  // Output byte mux; idle and padding emit zero
  always_comb begin
    bus.out_byte = '0;
    case (state)
      ST_HDR:  bus.out_byte = hdr_byte;
      ST_PIX:  bus.out_byte = hold_full ? pix_byte : 8'h00;
      default: bus.out_byte = '0;
    endcase
  end

  // Pixel holding register: decouples pixel input from output stalls
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      hold <= '0;
    else if (pix_take)
      hold <= '{r: bus.DATA_R, g: bus.DATA_G, b: bus.DATA_B};
  end

  // File byte counter, drives out_last on the final byte
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      byte_cnt <= '0;
    else if ((state == ST_IDLE) && bus.start)
      byte_cnt <= '0;
    else if (xfer)
      byte_cnt <= byte_cnt + 32'd1;
  end

  // Frame sequencing: header, then per row pixels and padding, then done
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      hdr_idx   <= '0;
      col       <= '0;
      row       <= '0;
      pad_cnt   <= '0;
      phase     <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_HDR;
            hdr_idx   <= '0;
            col       <= '0;
            row       <= '0;
            pad_cnt   <= '0;
            phase     <= '0;
            hold_full <= 1'b0;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            if (hdr_idx == 6'(BMP_HEADER_NUM - 1)) begin
              state <= ST_PIX;
              col   <= '0;
              row   <= '0;
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        ST_PIX: begin
          if (pix_take) begin
            hold_full <= 1'b1;
            phase     <= '0;
          end else if (xfer) begin
            if (phase == 2'd2) begin
              hold_full <= 1'b0;
              phase     <= '0;
              if (col == 11'(WIDTH - 1)) begin
                col <= '0;
                if (PAD_BYTES > 0) begin
                  state   <= ST_PAD;
                  pad_cnt <= '0;
                end else if (row_last) begin
                  state <= ST_FIN;
                end else begin
                  row <= row + 10'd1;
                end
              end else begin
                col <= col + 11'd1;
              end
            end else begin
              phase <= phase + 2'd1;
            end
          end
        end
        ST_PAD: begin
          if (xfer) begin
            if (pad_cnt == 2'(PAD_BYTES - 1)) begin
              pad_cnt <= '0;
              if (row_last) begin
                state <= ST_FIN;
              end else begin
                state <= ST_PIX;
                row   <= row + 10'd1;
              end
            end else begin
              pad_cnt <= pad_cnt + 2'd1;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_write_stream.sv
// Bench for bmp_write_stream: three DUT geometries share one stimulus
// bundle; a queue model builds the expected file from BMP layout rules and
// a negedge process compares every transferred byte, stall hold and done.
module tb_bmp_write_stream;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic       start = 1'b0, pix_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] dr = '0, dg = '0, db = '0;
  int         sel = 0;
  bit         rand_rdy = 1'b0, active = 1'b0;

  logic       v_valid[3], v_last[3], v_busy[3], v_done[3], v_prdy[3];
  logic [7:0] v_byte[3];

  // g0: 2x2 BGR (pad 2), g1: 4x1 RGB (no pad), g2: 3x3 BGR (pad 3)
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : (g == 1) ? 4 : 3;
    localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int B = (g == 1) ? 0 : 1;
    bmp_write_stream_if bus();
    assign bus.start     = start && (sel == g);
    assign bus.pix_valid = pix_valid && (sel == g);
    assign bus.DATA_R    = dr;
    assign bus.DATA_G    = dg;
    assign bus.DATA_B    = db;
    assign bus.out_ready = out_ready;
    bmp_write_stream #(.WIDTH(W), .HEIGHT(H), .BGR_ORDER(B)) u_dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
    );
    assign v_valid[g] = bus.out_valid;
    assign v_last[g]  = bus.out_last;
    assign v_busy[g]  = bus.busy;
    assign v_done[g]  = bus.done;
    assign v_prdy[g]  = bus.pix_ready;
    assign v_byte[g]  = bus.out_byte;
  end

  logic       o_valid, o_last, o_busy, o_done, o_prdy;
  logic [7:0] o_byte;
  assign o_valid = v_valid[sel];
  assign o_last  = v_last[sel];
  assign o_busy  = v_busy[sel];
  assign o_done  = v_done[sel];
  assign o_prdy  = v_prdy[sel];
  assign o_byte  = v_byte[sel];

  int         checks = 0, fails = 0;
  logic [7:0] exp_q[$], got_q[$], ref_q[$];
  int         exp_idx = 0;
  bit         stall_prev = 1'b0, done_next = 1'b0;
  logic [7:0] prev_byte = '0;
  logic       prev_last = 1'b0;
  logic [7:0] pr[16], pg[16], pb[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  // Expected file built straight from the BMP layout
  task automatic build_exp(input int w, input int h, input int bgr);
    int pad, stride;
    pad    = (4 - (w * 3) % 4) % 4;
    stride = w * 3 + pad;
    exp_q.delete();
    put(32'h4D42, 2);
    put(54 + stride * h, 4);
    put(0, 4);
    put(54, 4);
    put(40, 4);
    put(w, 4);
    put(-h, 4);
    put(1, 2);
    put(24, 2);
    put(0, 4);
    put(stride * h, 4);
    put(2835, 4);
    put(2835, 4);
    put(0, 4);
    put(0, 4);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (bgr != 0) begin
          exp_q.push_back(pb[r*w+c]); exp_q.push_back(pg[r*w+c]); exp_q.push_back(pr[r*w+c]);
        end else begin
          exp_q.push_back(pr[r*w+c]); exp_q.push_back(pg[r*w+c]); exp_q.push_back(pb[r*w+c]);
        end
      end
      for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
    end
  endtask

  // Output sink ready: always 1, or a coin flip each cycle
  initial forever begin
    @(posedge HCLK);
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every cycle while a frame is live
  initial forever begin
    @(negedge HCLK);
    if (active && !HRESET) begin
      if (stall_prev) begin
        chk("stall_valid", int'(o_valid), 1);
        chk("stall_byte", int'(o_byte), int'(prev_byte));
        chk("stall_last", int'(o_last), int'(prev_last));
      end
      chk("done", int'(o_done), int'(done_next));
      done_next = 1'b0;
      if (o_valid && out_ready) begin
        if (exp_idx < exp_q.size()) begin
          chk("byte", int'(o_byte), int'(exp_q[exp_idx]));
          chk("last", int'(o_last), int'(exp_idx == exp_q.size() - 1));
          if (exp_idx == exp_q.size() - 1) done_next = 1'b1;
        end else begin
          chk("overrun", exp_idx, exp_q.size() - 1);
        end
        got_q.push_back(o_byte);
        exp_idx++;
      end
      stall_prev = o_valid && !out_ready;
      prev_byte  = o_byte;
      prev_last  = o_last;
    end
  end

  task automatic arm(input int s, input int w, input int h, input int bgr, input bit rnd);
    sel = s;
    rand_rdy = rnd;
    build_exp(w, h, bgr);
    exp_idx = 0;
    got_q.delete();
    stall_prev = 1'b0;
    done_next = 1'b0;
    active = 1'b1;
    @(posedge HCLK); #1 start = 1'b1;
    @(posedge HCLK); #1 start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input int gap_at, input int start_at);
    int t, n1;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        pix_valid = 1'b0;
        repeat (5) @(posedge HCLK);
        n1 = exp_idx;
        repeat (15) @(posedge HCLK);
        chk("gap_quiet", exp_idx, n1);
        #1;
      end
      if (i == start_at) begin
        start = 1'b1;
        @(posedge HCLK); #1 start = 1'b0;
      end
      pix_valid = 1'b1;
      dr = pr[i]; dg = pg[i]; db = pb[i];
      t = 0;
      @(negedge HCLK);
      while (!o_prdy && t < 300) begin @(negedge HCLK); t++; end
      if (t >= 300) chk("pix_timeout", t, 0);
      @(posedge HCLK); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic finish_frame();
    int t;
    t = 0;
    while (t < 500) begin
      @(negedge HCLK);
      if (o_done) break;
      t++;
    end
    chk("done_seen", int'(t < 500), 1);
    @(negedge HCLK);
    chk("idle_busy", int'(o_busy), 0);
    active = 1'b0;
    chk("count", exp_idx, exp_q.size());
  endtask

  task automatic run_frame(input int s, input int w, input int h, input int bgr,
                           input bit rnd, input int gap_at, input int start_at);
    arm(s, w, h, bgr, rnd);
    drive_pixels(w * h, gap_at, start_at);
    finish_frame();
  endtask

  int pin_i[19] = '{0, 1, 2, 3, 4, 5, 10, 22, 23, 24, 25, 54, 55, 56, 57, 58, 59, 60, 61};
  int pin_v[19] = '{'h42, 'h4D, 'h46, 0, 0, 0, 'h36, 'hFE, 'hFF, 'hFF, 'hFF,
                    'h1E, 'h14, 'h0A, 'h3C, 'h32, 'h28, 0, 0};

  initial begin
    int t;
    // Reset state on every geometry
    repeat (2) @(posedge HCLK);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_byte", int'(o_byte), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_prdy", int'(o_prdy), 0);
    end
    @(posedge HCLK); #1 HRESET = 1'b0;

    // 2x2 BGR, unstalled
    pr[0] = 10; pg[0] = 20; pb[0] = 30;
    pr[1] = 40; pg[1] = 50; pb[1] = 60;
    pr[2] = 70; pg[2] = 80; pb[2] = 90;
    pr[3] = 1;  pg[3] = 2;  pb[3] = 3;
    run_frame(0, 2, 2, 1, 1'b0, -1, -1);
    chk("m_size", exp_q.size(), 70);
    chk("d_size", got_q.size(), 70);
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("m_pin%0d", pin_i[k]), int'(exp_q[pin_i[k]]), pin_v[k]);
      if (got_q.size() > pin_i[k])
        chk($sformatf("d_pin%0d", pin_i[k]), int'(got_q[pin_i[k]]), pin_v[k]);
    end
    if (got_q.size() == 70) chk("d_final", int'(got_q[69]), 0);

    // 4x1 RGB, no padding
    for (int i = 0; i < 4; i++) begin
      pr[i] = 8'(3*i+1); pg[i] = 8'(3*i+2); pb[i] = 8'(3*i+3);
    end
    run_frame(1, 4, 1, 0, 1'b0, -1, -1);
    chk("w4_size", got_q.size(), 66);
    if (got_q.size() == 66) begin
      chk("w4_first_r", int'(got_q[54]), 1);
      chk("w4_last_b", int'(got_q[65]), 12);
    end

    // 3x3 BGR, unstalled reference then random stalls
    for (int i = 0; i < 9; i++) begin
      pr[i] = 8'(8'h20 + i); pg[i] = 8'(8'h40 + i); pb[i] = 8'(8'h80 + i);
    end
    run_frame(2, 3, 3, 1, 1'b0, -1, -1);
    chk("w3_size", got_q.size(), 90);
    ref_q = got_q;
    run_frame(2, 3, 3, 1, 1'b1, -1, -1);
    chk("stall_size", got_q.size(), ref_q.size());
    for (int k = 0; k < ref_q.size() && k < got_q.size(); k++)
      if (got_q[k] != ref_q[k]) chk($sformatf("stall_eq%0d", k), int'(got_q[k]), int'(ref_q[k]));
    chk("stall_eq_last", int'(got_q[got_q.size()-1]), int'(ref_q[ref_q.size()-1]));

    // Pixel gap mid-row, then start pulse during PIX
    run_frame(2, 3, 3, 1, 1'b0, 4, -1);
    run_frame(2, 3, 3, 1, 1'b0, -1, 2);

    // Reset in the middle of the header, then a clean frame
    arm(2, 3, 3, 1, 1'b0);
    t = 0;
    while (exp_idx < 30 && t < 200) begin @(negedge HCLK); t++; end
    chk("hdr30_reached", int'(t < 200), 1);
    #2;
    active = 1'b0;
    HRESET = 1'b1;
    #1;
    chk("ar_valid", int'(o_valid), 0);
    chk("ar_byte", int'(o_byte), 0);
    chk("ar_last", int'(o_last), 0);
    chk("ar_busy", int'(o_busy), 0);
    chk("ar_done", int'(o_done), 0);
    chk("ar_prdy", int'(o_prdy), 0);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    run_frame(2, 3, 3, 1, 1'b0, -1, -1);
    chk("ar_size", got_q.size(), 90);
    if (got_q.size() == 90) chk("ar_byte0", int'(got_q[0]), 'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
